int_to_float_encoder: RTL and testbench
=======================================

Name: int_to_float_encoder

Overview:
- Converts a signed two's-complement integer to an IEEE 754 float with parameterized exponent and mantissa widths.
- This is the float producer. Its output feeds float consumers such as the threshold comparators.
- Normalization is iterative, one left-shift per cycle, followed by a single round-to-nearest-even cycle.
- Valid/ready handshake on both input and output.
- Processes one conversion at a time, with no pipelining.

Parameters:
- I_SIZE, 32, width of the signed integer input.
- E_SIZE, 8, exponent field width.
- C_SIZE, 23, mantissa (fraction) field width.
- Constraints: C_SIZE <= I_SIZE-2; bias + I_SIZE-1 < 2^E_SIZE - 1, so exponent overflow cannot occur.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  I_SIZE  signed integer operand.
- in_valid  in  1  operand present.
- in_ready  out  1  encoder idle; the operand is accepted on an edge where in_valid && in_ready.
- out_data  out  E_SIZE+C_SIZE+1  float result {sign, exponent, mantissa}.
- out_valid  out  1  result present; held until accepted.
- out_ready  in  1  consumer accepts; the result is taken on an edge where out_valid && out_ready.

Behaviour:
- Reset (async assert, any state):
  - state goes to IDLE; in_ready=1, out_valid=0, out_data=0.
  - All internal registers are cleared and any in-flight conversion is discarded.
  - On deassertion, the first accept is possible at the next edge.
- States:
  - IDLE: in_ready=1. On accept:
    - capture sign = in_data[I_SIZE-1];
    - mag = |in_data| as an I_SIZE-bit unsigned value (the most negative input gives mag = 2^(I_SIZE-1));
    - shift count = 0.
    - If mag == 0, load out_data = 0 (+0.0) and go to DONE. Otherwise go to NORM.
  - NORM: in_ready=0.
    - If mag[I_SIZE-1] == 1, go to ROUND.
    - Otherwise shift mag left by 1 and increment the count.
    - With s leading zeros, NORM lasts s+1 cycles.
  - ROUND: in_ready=0, one cycle.
    - mant = mag[I_SIZE-2 : I_SIZE-1-C_SIZE].
    - guard = mag[I_SIZE-2-C_SIZE].
    - sticky = OR of all lower bits.
    - Round up when guard && (sticky || mant[0]).
    - If incrementing mant carries out: mant = 0 and exponent += 1.
    - exponent = bias + (I_SIZE-1) - s, where bias = 2^(E_SIZE-1) - 1.
    - Load out_data = {sign, exponent, mant} and go to DONE.
  - DONE: out_valid=1; out_data is stable.
    - When out_ready is sampled high, go to IDLE with out_valid=0.
    - No new operand is accepted in the same edge.
    - in_ready rises the cycle after the handshake.
- Latency:
  - Nonzero input: out_valid rises s+2 edges after the accepting edge.
  - Zero input: out_valid rises 1 edge after the accepting edge.
  - Minimum repeat interval is latency + 1 cycle.
- Backpressure: out_ready low holds DONE indefinitely; out_data and out_valid stay constant.
- in_valid while busy is ignored; the source must hold it until in_ready.
- The encoder never produces -0, subnormals, Inf or NaN.
- Register all outputs. No combinational path from in_* to out_*.

Decomposition:
- Shared package float_pkg:
  - E_SIZE/C_SIZE defaults;
  - BIAS constant function;
  - state encoding constants ST_IDLE, ST_NORM, ST_ROUND, ST_DONE;
  - float field slice helpers.
- Sub-module float_round_ne: combinational rounding of the normalized mag into {exponent, mant} with carry.
  - Reusable by later float arithmetic blocks.
- The FSM and the normalizer stay in the top module.

Test Plan:
- in_data=1, out_ready=1 -> out_data=0x3F800000; out_valid 33 edges after accept (s=31). Repeat with -1 -> 0xBF800000.
- in_data=0 -> out_data=0x00000000; out_valid 1 edge after accept; never 0x80000000.
- in_data=16777217 -> 0x4B800000 (tie rounds down to even). in_data=16777219 -> 0x4B800002 (tie rounds up).
- in_data=0x7FFFFFFF -> 0x4F000000 via the mantissa carry into the exponent. in_data=0x80000000 -> 0xCF000000 with latency 2.
- Backpressure: out_ready=0 for 20 cycles in DONE -> out_data/out_valid held and in_ready=0; a new in_valid is ignored until 1 cycle after the out handshake.
- reset_n pulsed low mid-NORM (in_data=1, after 10 cycles) -> immediate in_ready=1, out_valid=0, out_data=0. The next conversion of 3 yields 0x40400000.

Source files
------------

// File: rtl/float_pkg.sv
// Shared float definitions: default field widths, exponent bias, encoder states
// and field slice helpers for the default single-precision layout.
package float_pkg;

    localparam int E_SIZE_DEF = 8;
    localparam int C_SIZE_DEF = 23;
    localparam int F_SIZE_DEF = E_SIZE_DEF + C_SIZE_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int float_bias(input int e_size);
        return (1 << (e_size - 1)) - 1;
    endfunction

    function automatic logic float_sign(input logic [F_SIZE_DEF-1:0] f);
        return f[F_SIZE_DEF-1];
    endfunction

    function automatic logic [E_SIZE_DEF-1:0] float_exp(input logic [F_SIZE_DEF-1:0] f);
        return f[F_SIZE_DEF-2 -: E_SIZE_DEF];
    endfunction

    function automatic logic [C_SIZE_DEF-1:0] float_mant(input logic [F_SIZE_DEF-1:0] f);
        return f[C_SIZE_DEF-1:0];
    endfunction

endpackage

// File: rtl/float_round_ne.sv
// Round-to-nearest-even of a normalized magnitude (MSB set) into exponent and
// fraction fields; a fraction carry-out bumps the exponent.
module float_round_ne
    import float_pkg::*;
#(
    parameter int I_SIZE = 32,
    parameter int E_SIZE = E_SIZE_DEF,
    parameter int C_SIZE = C_SIZE_DEF,
    parameter int SW     = $clog2(I_SIZE)
) (
    input  logic [I_SIZE-1:0] mag,
    input  logic [SW-1:0]     shift,
    output logic [E_SIZE-1:0] exponent,
    output logic [C_SIZE-1:0] mant
);

    localparam int LOW     = I_SIZE - 2 - C_SIZE;
    localparam int EXP_TOP = float_bias(E_SIZE) + I_SIZE - 1;
    localparam logic [I_SIZE-1:0] LOW_MASK = (I_SIZE'(1) << LOW) - I_SIZE'(1);

    logic [C_SIZE-1:0] mant_raw;
    logic [C_SIZE:0]   mant_sum;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [E_SIZE-1:0] exp_base;

    // Bits below the guard are masked rather than sliced so C_SIZE = I_SIZE-2 still works.
    always_comb begin
        mant_raw = mag[I_SIZE-2 -: C_SIZE];
        guard    = mag[LOW];
        sticky   = |(mag & LOW_MASK);
        round_up = guard & (sticky | mant_raw[0]);
        mant_sum = {1'b0, mant_raw} + (C_SIZE+1)'(round_up);
        exp_base = E_SIZE'(EXP_TOP) - E_SIZE'(shift);
        exponent = exp_base + E_SIZE'(mant_sum[C_SIZE]);
        mant     = mant_sum[C_SIZE-1:0];
    end

endmodule

// File: rtl/int_to_float_encoder.sv
// Signed integer to IEEE 754 float encoder: iterative one-bit-per-cycle
// normalization followed by a single round-to-nearest-even cycle.
module int_to_float_encoder
    import float_pkg::*;
#(
    parameter int I_SIZE = 32,
    parameter int E_SIZE = E_SIZE_DEF,
    parameter int C_SIZE = C_SIZE_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [I_SIZE-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [E_SIZE+C_SIZE:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int SW = $clog2(I_SIZE);

    state_t                  state;
    state_t                  state_next;
    logic                    sign_r;
    logic [I_SIZE-1:0]       mag_r;
    logic [I_SIZE-1:0]       in_mag;
    logic [SW-1:0]           shift_r;
    logic [E_SIZE-1:0]       rnd_exp;
    logic [C_SIZE-1:0]       rnd_mant;
    logic [E_SIZE+C_SIZE:0]  out_data_r;
    logic                    accept;

    // The most negative input negates to itself, which is exactly 2^(I_SIZE-1) as unsigned.
    assign in_mag = in_data[I_SIZE-1] ? (~in_data + I_SIZE'(1)) : in_data;
    assign accept = in_valid && (state == ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (in_valid) state_next = (in_mag == '0) ? ST_DONE : ST_NORM;
            ST_NORM:  if (mag_r[I_SIZE-1]) state_next = ST_ROUND;
            ST_ROUND: state_next = ST_DONE;
            ST_DONE:  if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sign_r     <= 1'b0;
            mag_r      <= '0;
            shift_r    <= '0;
            out_data_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sign_r  <= in_data[I_SIZE-1];
                        mag_r   <= in_mag;
                        shift_r <= '0;
                        if (in_mag == '0) out_data_r <= '0;
                    end
                end
                ST_NORM: begin
                    if (!mag_r[I_SIZE-1]) begin
                        mag_r   <= mag_r << 1;
                        shift_r <= shift_r + SW'(1);
                    end
                end
                ST_ROUND: out_data_r <= {sign_r, rnd_exp, rnd_mant};
                default: ;
            endcase
        end
    end

    float_round_ne #(
        .I_SIZE (I_SIZE),
        .E_SIZE (E_SIZE),
        .C_SIZE (C_SIZE),
        .SW     (SW)
    ) u_round (
        .mag      (mag_r),
        .shift    (shift_r),
        .exponent (rnd_exp),
        .mant     (rnd_mant)
    );

    assign out_data = out_data_r;

endmodule

// File: tb/tb_int_to_float_encoder.sv
// Directed bench for int_to_float_encoder: vector table plus backpressure and
// mid-conversion reset sequences.
module tb_int_to_float_encoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] din;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    int_to_float_encoder #(.I_SIZE(32), .E_SIZE(8), .C_SIZE(23)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Counts edges after the current one until out_valid, sampling 1 time unit past each edge.
    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s timeout: out_valid still 0 after %0d edges, expected 1", name, lat);
        end
    endtask

    task automatic apply_stimulus(input string name, input logic [31:0] din,
                                  output logic [31:0] res, output int lat);
        @(negedge clock);
        check_output({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        wait_valid(name, lat);
        res = out_data;
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_output({name, " post_hs out_valid"}, 32'(out_valid), 32'd0);
        check_output({name, " post_hs in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        int          lat;

        vecs[0]  = '{"one",       32'd1,          32'h3F800000, 33};
        vecs[1]  = '{"minus_one", 32'hFFFFFFFF,   32'hBF800000, 33};
        vecs[2]  = '{"zero",      32'd0,          32'h00000000, 1};
        vecs[3]  = '{"tie_even",  32'd16777217,   32'h4B800000, 9};
        vecs[4]  = '{"tie_up",    32'd16777219,   32'h4B800002, 9};
        vecs[5]  = '{"max_pos",   32'h7FFFFFFF,   32'h4F000000, 3};
        vecs[6]  = '{"min_neg",   32'h80000000,   32'hCF000000, 2};
        vecs[7]  = '{"two",       32'd2,          32'h40000000, 32};
        vecs[8]  = '{"minus_5",   32'hFFFFFFFB,   32'hC0A00000, 31};
        vecs[9]  = '{"hundred",   32'd100,        32'h42C80000, 27};
        vecs[10] = '{"pow24",     32'h01000000,   32'h4B800000, 9};
        vecs[11] = '{"neg_tie",   32'hFEFFFFFD,   32'hCB800002, 9};

        #1;
        check_output("reset in_ready", 32'(in_ready), 32'd1);
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset out_data", out_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].name, vecs[i].din, res, lat);
            check_output({vecs[i].name, " data"}, res, vecs[i].exp_data);
            check_output({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Backpressure: hold DONE for 20 cycles while a new operand waits.
        @(negedge clock);
        in_data  = 32'd3;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        wait_valid("bp first", lat);
        held = out_data;
        check_output("bp first data", held, 32'h40400000);
        @(negedge clock);
        in_data  = 32'd7;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            check_output("bp hold out_valid", 32'(out_valid), 32'd1);
            check_output("bp hold out_data", out_data, held);
            check_output("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check_output("bp hs out_valid", 32'(out_valid), 32'd0);
        check_output("bp hs in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check_output("bp accept in_ready", 32'(in_ready), 32'd0);
        wait_valid("bp second", lat);
        check_output("bp second data", out_data, 32'h40E00000);
        check_output("bp second latency", 32'(lat), 32'd31);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;

        // Reset asserted in the middle of normalization.
        @(negedge clock);
        in_data  = 32'd1;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_output("rst mid in_ready", 32'(in_ready), 32'd1);
        check_output("rst mid out_valid", 32'(out_valid), 32'd0);
        check_output("rst mid out_data", out_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        apply_stimulus("after_rst", 32'd3, res, lat);
        check_output("after_rst data", res, 32'h40400000);
        check_output("after_rst latency", 32'(lat), 32'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
